// File: rtl/bottle_pkg.sv
// Shared types and constants for the pill-bottling sequence controller.
package bottle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BOT = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_FILL     = 3'd3,
        ST_ADVANCE  = 3'd4,
        ST_DONE     = 3'd5,
        ST_JAM      = 3'd6
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // A usable target has two legal BCD digits and is not 00.
    function automatic logic bcd2_target_ok(input bcd_digit_t hi, input bcd_digit_t lo);
        return (hi <= BCD_MAX_DIGIT) && (lo <= BCD_MAX_DIGIT) &&
               ((hi != 4'd0) || (lo != 4'd0));
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter with clear, increment and a target compare.
module bcd2_counter
    import bottle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [3:0] tgt_h,
    input  logic [3:0] tgt_l,
    output logic [3:0] cnt_h,
    output logic [3:0] cnt_l,
    output logic       hit
);

    bcd_digit_t cnt_h_q, cnt_l_q;
    bcd_digit_t cnt_h_d, cnt_l_d;
    bcd_digit_t nxt_h, nxt_l;

    always_comb begin
        nxt_l = cnt_l_q + 4'd1;
        nxt_h = cnt_h_q;
        if (cnt_l_q >= BCD_MAX_DIGIT) begin
            nxt_l = '0;
            nxt_h = (cnt_h_q >= BCD_MAX_DIGIT) ? '0 : cnt_h_q + 4'd1;
        end

        cnt_h_d = cnt_h_q;
        cnt_l_d = cnt_l_q;
        if (clr) begin
            cnt_h_d = '0;
            cnt_l_d = '0;
        end else if (inc) begin
            cnt_h_d = nxt_h;
            cnt_l_d = nxt_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h_q <= '0;
            cnt_l_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_l_q <= cnt_l_d;
        end
    end

    // Compares the value this counter will hold after the coming edge, so the
    // caller can react on the same edge that the count reaches the target.
    assign hit   = (cnt_h_d == tgt_h) && (cnt_l_d == tgt_l);
    assign cnt_h = cnt_h_q;
    assign cnt_l = cnt_l_q;

endmodule

// File: rtl/bottle_fill_seq.sv
// Pill-bottling sequencer: conveyor/gate control, BCD pill and bottle counts,
// batch-complete and jam detection.
module bottle_fill_seq #(
    parameter int unsigned JAM_TIMEOUT = 1000,
    parameter int unsigned SETTLE_CYC  = 4
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       start,
    input  logic       hold,
    input  logic [3:0] per_bot_L,
    input  logic [3:0] per_bot_H,
    input  logic [3:0] bot_tgt_L,
    input  logic [3:0] bot_tgt_H,
    input  logic       pill_pulse,
    input  logic       bottle_present,
    output logic       conveyor_run,
    output logic       gate_open,
    output logic [3:0] nowL,
    output logic [3:0] nowH,
    output logic [3:0] seqL,
    output logic [3:0] seqH,
    output logic       allFull,
    output logic       jam_err,
    output logic [2:0] state
);

    import bottle_pkg::*;

    localparam int unsigned TW = $clog2(JAM_TIMEOUT);
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TW-1:0] JAM_LAST    = TW'(JAM_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_e        state_q, state_d;
    logic [7:0]    per_bot_q, per_bot_d;
    logic [7:0]    bot_tgt_q, bot_tgt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          conveyor_q, conveyor_d;
    logic          gate_q, gate_d;
    logic          all_full_q, all_full_d;
    logic          jam_err_q, jam_err_d;

    logic active, frozen, cfg_ok, accept, adv_leave;
    logic now_clr, now_inc, now_hit;
    logic seq_clr, seq_inc, seq_hit;

    assign active = (state_q == ST_WAIT_BOT) || (state_q == ST_SETTLE) ||
                    (state_q == ST_FILL)     || (state_q == ST_ADVANCE);
    assign frozen = active && hold;
    assign cfg_ok = bcd2_target_ok(per_bot_H, per_bot_L) &&
                    bcd2_target_ok(bot_tgt_H, bot_tgt_L);

    // Counter controls are kept outside the state logic so that the counters'
    // look-ahead hit outputs never feed back into their own inc/clr inputs.
    assign accept    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && cfg_ok;
    assign adv_leave = !frozen && (state_q == ST_ADVANCE) && !bottle_present;
    assign now_inc   = !frozen && (state_q == ST_FILL) && pill_pulse;
    assign seq_inc   = now_inc && now_hit;
    assign seq_clr   = accept;
    assign now_clr   = accept || (adv_leave && !seq_hit);

    bcd2_counter u_now (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (now_clr),
        .inc   (now_inc),
        .tgt_h (per_bot_q[7:4]),
        .tgt_l (per_bot_q[3:0]),
        .cnt_h (nowH),
        .cnt_l (nowL),
        .hit   (now_hit)
    );

    bcd2_counter u_seq (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (seq_clr),
        .inc   (seq_inc),
        .tgt_h (bot_tgt_q[7:4]),
        .tgt_l (bot_tgt_q[3:0]),
        .cnt_h (seqH),
        .cnt_l (seqL),
        .hit   (seq_hit)
    );

    always_comb begin
        state_d   = state_q;
        per_bot_d = per_bot_q;
        bot_tgt_d = bot_tgt_q;
        settle_d  = settle_q;
        timer_d   = timer_q;

        if (!frozen) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_d   = ST_WAIT_BOT;
                        per_bot_d = {per_bot_H, per_bot_L};
                        bot_tgt_d = {bot_tgt_H, bot_tgt_L};
                    end
                end
                ST_WAIT_BOT: begin
                    if (bottle_present) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end
                end
                ST_SETTLE: begin
                    if (!bottle_present) begin
                        state_d = ST_WAIT_BOT;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_d = ST_FILL;
                        timer_d = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                ST_FILL: begin
                    if (pill_pulse) begin
                        timer_d = '0;
                        if (now_hit) begin
                            state_d = ST_ADVANCE;
                        end
                    end else if (timer_q == JAM_LAST) begin
                        state_d = ST_JAM;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_ADVANCE: begin
                    if (adv_leave) begin
                        state_d = seq_hit ? ST_DONE : ST_WAIT_BOT;
                    end
                end
                ST_JAM: begin
                    if (start) begin
                        state_d = ST_FILL;
                        timer_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        conveyor_d = ((state_d == ST_WAIT_BOT) || (state_d == ST_ADVANCE)) && !hold;
        gate_d     = (state_d == ST_FILL) && !hold;
        all_full_d = (state_d == ST_DONE);
        jam_err_d  = (state_d == ST_JAM);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= ST_IDLE;
            per_bot_q  <= '0;
            bot_tgt_q  <= '0;
            settle_q   <= '0;
            timer_q    <= '0;
            conveyor_q <= 1'b0;
            gate_q     <= 1'b0;
            all_full_q <= 1'b0;
            jam_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_bot_q  <= per_bot_d;
            bot_tgt_q  <= bot_tgt_d;
            settle_q   <= settle_d;
            timer_q    <= timer_d;
            conveyor_q <= conveyor_d;
            gate_q     <= gate_d;
            all_full_q <= all_full_d;
            jam_err_q  <= jam_err_d;
        end
    end

    assign conveyor_run = conveyor_q;
    assign gate_open    = gate_q;
    assign allFull      = all_full_q;
    assign jam_err      = jam_err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_bottle_fill_seq.sv
// Directed self-checking bench for bottle_fill_seq.
module tb_bottle_fill_seq;

    localparam int JT     = 40;
    localparam int SETTLE = 4;

    logic       CLK, RST_n, start, hold, pill_pulse, bottle_present;
    logic [3:0] per_bot_L, per_bot_H, bot_tgt_L, bot_tgt_H;
    logic       conveyor_run, gate_open, allFull, jam_err;
    logic [3:0] nowL, nowH, seqL, seqH;
    logic [2:0] state;

    logic [7:0]  now_v, seq_v;
    logic [22:0] outs;
    assign now_v = {nowH, nowL};
    assign seq_v = {seqH, seqL};
    assign outs  = {conveyor_run, gate_open, nowH, nowL, seqH, seqL, allFull, jam_err, state};

    int total = 0;
    int bad = 0;
    int gate_viol = 0;

    bottle_fill_seq #(.JAM_TIMEOUT(JT), .SETTLE_CYC(SETTLE)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .hold(hold),
        .per_bot_L(per_bot_L), .per_bot_H(per_bot_H),
        .bot_tgt_L(bot_tgt_L), .bot_tgt_H(bot_tgt_H),
        .pill_pulse(pill_pulse), .bottle_present(bottle_present),
        .conveyor_run(conveyor_run), .gate_open(gate_open),
        .nowL(nowL), .nowH(nowH), .seqL(seqL), .seqH(seqH),
        .allFull(allFull), .jam_err(jam_err), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST_n && gate_open && state != 3'd3) gate_viol++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] pb, input logic [7:0] bt);
        per_bot_H = pb[7:4]; per_bot_L = pb[3:0];
        bot_tgt_H = bt[7:4]; bot_tgt_L = bt[3:0];
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic to_fill();
        bottle_present = 1'b1;
        step();
        repeat (SETTLE) step();
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        repeat (3) step();
        total++;
        if (outs !== 23'd0) begin bad++; $display("FAIL reset_held: outs=%h expected 0", outs); end
        RST_n = 1'b1;
        step();
        total++;
        if (outs !== 23'd0) begin bad++; $display("FAIL reset_release: outs=%h expected 0", outs); end
    endtask

    task automatic test_basic();
        set_cfg(8'h03, 8'h02);
        pulse_start();
        total++;
        if (state !== 3'd1 || conveyor_run !== 1'b1) begin
            bad++; $display("FAIL basic_accept: state=%0d conv=%b expected 1/1", state, conveyor_run);
        end
        for (int b = 1; b <= 2; b++) begin
            bottle_present = 1'b1;
            step();
            total++;
            if (state !== 3'd2 || conveyor_run !== 1'b0) begin
                bad++; $display("FAIL basic_settle: state=%0d conv=%b expected 2/0", state, conveyor_run);
            end
            repeat (SETTLE - 1) step();
            total++;
            if (state !== 3'd2) begin bad++; $display("FAIL basic_settle_len: state=%0d expected 2", state); end
            step();
            total++;
            if (state !== 3'd3 || gate_open !== 1'b1) begin
                bad++; $display("FAIL basic_fill_entry: state=%0d gate=%b expected 3/1", state, gate_open);
            end
            for (int p = 1; p <= 3; p++) begin
                repeat (4) step();
                pill_pulse = 1'b1; step(); pill_pulse = 1'b0;
                total++;
                if (now_v !== 8'(p)) begin bad++; $display("FAIL basic_pill_count: now=%h expected %h", now_v, 8'(p)); end
            end
            total++;
            if (state !== 3'd4 || gate_open !== 1'b0 || conveyor_run !== 1'b1 || seq_v !== 8'(b)) begin
                bad++; $display("FAIL basic_advance: state=%0d gate=%b conv=%b seq=%h expected 4/0/1/%h",
                                state, gate_open, conveyor_run, seq_v, 8'(b));
            end
            bottle_present = 1'b0;
            step();
            total++;
            if (b == 1) begin
                if (state !== 3'd1 || now_v !== 8'h00 || seq_v !== 8'h01 || allFull !== 1'b0) begin
                    bad++; $display("FAIL basic_next_bottle: state=%0d now=%h seq=%h full=%b expected 1/00/01/0",
                                    state, now_v, seq_v, allFull);
                end
            end else begin
                if (state !== 3'd5 || allFull !== 1'b1 || conveyor_run !== 1'b0 || now_v !== 8'h03 || seq_v !== 8'h02) begin
                    bad++; $display("FAIL basic_done: state=%0d full=%b conv=%b now=%h seq=%h expected 5/1/0/03/02",
                                    state, allFull, conveyor_run, now_v, seq_v);
                end
            end
        end
        total++;
        if (gate_viol !== 0) begin bad++; $display("FAIL gate_outside_fill: count=%0d expected 0", gate_viol); end
    endtask

    task automatic test_carry();
        set_cfg(8'h12, 8'h01);
        pulse_start();
        total++;
        if (state !== 3'd1 || allFull !== 1'b0 || seq_v !== 8'h00 || now_v !== 8'h00) begin
            bad++; $display("FAIL carry_restart: state=%0d full=%b seq=%h now=%h expected 1/0/00/00",
                            state, allFull, seq_v, now_v);
        end
        to_fill();
        for (int p = 1; p <= 12; p++) begin
            pill_pulse = 1'b1; step(); pill_pulse = 1'b0;
            total++;
            if (now_v !== 8'(((p / 10) << 4) | (p % 10))) begin
                bad++; $display("FAIL carry_now: pulse=%0d now=%h expected %h", p, now_v, 8'(((p / 10) << 4) | (p % 10)));
            end
            if (p == 11) begin
                total++;
                if (state !== 3'd3) begin bad++; $display("FAIL carry_early_adv: state=%0d expected 3", state); end
            end
            if (p == 12) begin
                total++;
                if (state !== 3'd4 || gate_open !== 1'b0) begin
                    bad++; $display("FAIL carry_adv: state=%0d gate=%b expected 4/0", state, gate_open);
                end
            end
            step();
        end
        bottle_present = 1'b0;
        step();
        total++;
        if (state !== 3'd5 || allFull !== 1'b1) begin bad++; $display("FAIL carry_done: state=%0d full=%b expected 5/1", state, allFull); end
    endtask

    task automatic test_jam();
        set_cfg(8'h05, 8'h01);
        pulse_start();
        to_fill();
        repeat (JT - 1) step();
        total++;
        if (state !== 3'd3 || jam_err !== 1'b0) begin bad++; $display("FAIL jam_early: state=%0d jam=%b expected 3/0", state, jam_err); end
        step();
        total++;
        if (state !== 3'd6 || jam_err !== 1'b1 || gate_open !== 1'b0 || conveyor_run !== 1'b0) begin
            bad++; $display("FAIL jam_entry: state=%0d jam=%b gate=%b conv=%b expected 6/1/0/0",
                            state, jam_err, gate_open, conveyor_run);
        end
        repeat (3) step();
        pulse_start();
        total++;
        if (state !== 3'd3 || jam_err !== 1'b0 || gate_open !== 1'b1 || now_v !== 8'h00) begin
            bad++; $display("FAIL jam_clear: state=%0d jam=%b gate=%b now=%h expected 3/0/1/00",
                            state, jam_err, gate_open, now_v);
        end
        pill_pulse = 1'b1; step(); step(); pill_pulse = 1'b0;
        repeat (JT - 1) step();
        total++;
        if (state !== 3'd3) begin bad++; $display("FAIL jam_rearm_early: state=%0d expected 3", state); end
        step();
        total++;
        if (state !== 3'd6 || now_v !== 8'h02) begin bad++; $display("FAIL jam_rearm: state=%0d now=%h expected 6/02", state, now_v); end
        pulse_start();
        total++;
        if (state !== 3'd3 || now_v !== 8'h02) begin bad++; $display("FAIL jam_resume_now: state=%0d now=%h expected 3/02", state, now_v); end
        pill_pulse = 1'b1; repeat (3) step(); pill_pulse = 1'b0;
        bottle_present = 1'b0;
        step();
        total++;
        if (state !== 3'd5 || now_v !== 8'h05) begin bad++; $display("FAIL jam_finish: state=%0d now=%h expected 5/05", state, now_v); end
    endtask

    task automatic test_hold();
        int gate_seen;
        gate_seen = 0;
        set_cfg(8'h04, 8'h01);
        pulse_start();
        to_fill();
        pill_pulse = 1'b1; step(); pill_pulse = 1'b0;
        hold = 1'b1;
        for (int i = 0; i < 50; i++) begin
            pill_pulse = (i % 5 == 2);
            step();
            if (gate_open !== 1'b0) gate_seen++;
        end
        pill_pulse = 1'b0;
        total++;
        if (gate_seen !== 0) begin bad++; $display("FAIL hold_gate: cycles_open=%0d expected 0", gate_seen); end
        total++;
        if (state !== 3'd3 || now_v !== 8'h01 || jam_err !== 1'b0) begin
            bad++; $display("FAIL hold_freeze: state=%0d now=%h jam=%b expected 3/01/0", state, now_v, jam_err);
        end
        hold = 1'b0;
        step();
        total++;
        if (gate_open !== 1'b1) begin bad++; $display("FAIL hold_release_gate: gate=%b expected 1", gate_open); end
        pill_pulse = 1'b1; repeat (3) step(); pill_pulse = 1'b0;
        total++;
        if (state !== 3'd4 || now_v !== 8'h04) begin bad++; $display("FAIL hold_resume: state=%0d now=%h expected 4/04", state, now_v); end
        bottle_present = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        set_cfg(8'h03, 8'h02);
        pulse_start();
        to_fill();
        pill_pulse = 1'b1; repeat (3) step(); pill_pulse = 1'b0;
        total++;
        if (state !== 3'd4 || conveyor_run !== 1'b1) begin
            bad++; $display("FAIL areset_setup: state=%0d conv=%b expected 4/1", state, conveyor_run);
        end
        #3;
        RST_n = 1'b0;
        #1;
        total++;
        if (outs !== 23'd0) begin bad++; $display("FAIL areset_immediate: outs=%h expected 0", outs); end
        step();
        RST_n = 1'b1;
        bottle_present = 1'b0;
        step();
        total++;
        if (outs !== 23'd0) begin bad++; $display("FAIL areset_after: outs=%h expected 0", outs); end
    endtask

    task automatic test_invalid_cfg();
        set_cfg(8'h03, 8'h00);
        pulse_start();
        total++;
        if (outs !== 23'd0) begin bad++; $display("FAIL cfg_zero_target: outs=%h expected 0", outs); end
        set_cfg(8'h0A, 8'h01);
        pulse_start();
        total++;
        if (outs !== 23'd0) begin bad++; $display("FAIL cfg_bad_digit: outs=%h expected 0", outs); end
        set_cfg(8'h03, 8'h01);
        pulse_start();
        total++;
        if (state !== 3'd1) begin bad++; $display("FAIL cfg_valid_accept: state=%0d expected 1", state); end
    endtask

    initial begin
        RST_n = 1'b0; start = 1'b0; hold = 1'b0; pill_pulse = 1'b0; bottle_present = 1'b0;
        per_bot_L = '0; per_bot_H = '0; bot_tgt_L = '0; bot_tgt_H = '0;
        test_reset();
        test_basic();
        test_carry();
        test_jam();
        test_hold();
        test_async_reset();
        test_invalid_cfg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
